// File: rtl/tick_sched.sv
// tick_sched: four programmable clock-enable dividers (RNG, asteroid, ship,
// bullet timing) with a three-state reconfiguration handshake.
// Reset input 'rst' is asynchronous and active-low.
module tick_sched #(
  parameter int DW      = 8,
  parameter int RST_DIV = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          cfg_valid,
  input  logic [1:0]    cfg_sel,
  input  logic [DW-1:0] cfg_div,
  output logic          cfg_ready,
  output logic          busy,
  output logic [3:0]    tick
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SYNC
  } state_e;

  state_e state_q, state_d;

  logic [1:0]          sel_q, sel_d;
  logic [DW-1:0]       capDiv_q, capDiv_d;
  logic [3:0][DW-1:0]  div_q, div_d;
  logic [3:0][DW-1:0]  cnt_q, cnt_d;
  logic [3:0]          tick_q, tick_d;
  logic                loadEn;

  assign loadEn = (state_q == LOAD);
  assign tick   = tick_q;

  // Config handshake: accept in IDLE, commit in LOAD, one guard cycle in SYNC.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    capDiv_d  = capDiv_q;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_d  = LOAD;
          sel_d    = cfg_sel;
          capDiv_d = cfg_div;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = SYNC;
      end
      SYNC: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-channel divider: a reload beats a terminal count, a zero ratio parks the channel.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = '0;
    for (int n = 0; n < 4; n++) begin
      if (loadEn && (sel_q == 2'(n))) begin
        div_d[n]  = capDiv_q;
        cnt_d[n]  = '0;
        tick_d[n] = 1'b0;
      end else if (div_q[n] == '0) begin
        cnt_d[n]  = '0;
        tick_d[n] = 1'b0;
      end else if (run) begin
        if (cnt_q[n] == (div_q[n] - DW'(1))) begin
          cnt_d[n]  = '0;
          tick_d[n] = 1'b1;
        end else begin
          cnt_d[n]  = cnt_q[n] + DW'(1);
          tick_d[n] = 1'b0;
        end
      end
    end
  end

  // Handshake state and captured request; reset abandons any pending load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      capDiv_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      capDiv_q <= capDiv_d;
    end
  end

  // Divider ratios, counters and registered tick pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= {4{DW'(RST_DIV)}};
      cnt_q  <= '0;
      tick_q <= '0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 SHALL have parameter DW, default 8, meaning width of each channel's divide ratio and counter.
REQ-002 SHALL have parameter RST_DIV, default 5, meaning the divide ratio loaded into every channel at reset.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port run, input, 1, global enable; counters advance only while high.
REQ-006 SHALL have port cfg_valid, input, 1, configuration request.
REQ-007 SHALL have port cfg_sel, input, 2, target channel index 0..3.
REQ-008 SHALL have port cfg_div, input, DW, new divide ratio for the selected channel.
REQ-009 SHALL have port cfg_ready, output, 1, high when a configuration request is accepted.
REQ-010 SHALL have port busy, output, 1, high while a configuration is in progress.
REQ-011 SHALL have port tick, output, 4, one-cycle enable pulse per channel (RNG, asteroid, ship, bullet timing).

Function
REQ-012 SHALL hold per channel n a divide register div[n] (DW bits) and a counter cnt[n] (DW bits).
REQ-013 SHALL, while run=1 and div[n]!=0, on each clk edge: if cnt[n]==div[n]-1 then cnt[n]<=0 and tick[n]<=1, else cnt[n]<=cnt[n]+1 and tick[n]<=0.
REQ-014 SHALL, with run held high, produce tick[n] high exactly one cycle in every div[n] cycles; div[n]=1 gives tick[n] high every cycle.
REQ-015 SHALL treat div[n]=0 as channel disabled: cnt[n] held at 0, tick[n]=0.
REQ-016 SHALL, while run=0, hold every cnt[n] unchanged and drive tick=0; configuration remains accepted.
REQ-017 SHALL, on resuming run, continue each counter from its held value without losing or adding cycles.
REQ-018 SHALL implement a config FSM with states IDLE, LOAD, SYNC; IDLE->LOAD on cfg_valid&cfg_ready, LOAD->SYNC unconditionally, SYNC->IDLE unconditionally.
REQ-019 SHALL drive cfg_ready=1 only in IDLE and busy=1 only in LOAD or SYNC.
REQ-020 SHALL capture cfg_sel and cfg_div on the IDLE->LOAD edge; later changes on those inputs have no effect until the next acceptance.
REQ-021 SHALL, on the LOAD->SYNC edge, write the captured ratio to div[sel], clear cnt[sel] to 0 and force tick[sel]<=0.
REQ-022 SHALL, if channel sel would tick on the LOAD edge, suppress that tick (load wins); other channels are unaffected.
REQ-023 SHALL make the first tick of a reloaded channel occur div cycles after the LOAD edge when run stays high.
REQ-024 SHALL ignore cfg_valid in LOAD and SYNC; a request held high through SYNC is accepted on the next IDLE cycle.
REQ-025 SHALL accept at most one configuration every 3 cycles.
REQ-026 SHALL use wrap-free arithmetic: cnt never exceeds div-1; div=2^DW-1 is valid.

Reset
REQ-027 SHALL, while rst=0, asynchronously force state=IDLE, cnt all 0, div all RST_DIV, tick=0, cfg_ready=1, busy=0.
REQ-028 SHALL, on reset asserted mid-configuration, abandon the load; div[sel] returns to RST_DIV.
REQ-029 SHALL begin counting on the first rising clk edge after rst deasserts with run=1.

Verification
REQ-030 SHALL verify: reset release, run=1, no config -> each tick bit high on edge 5, 10, 15 after release, low otherwise.
REQ-031 SHALL verify: cfg_sel=2, cfg_div=3 accepted -> cfg_ready low 2 cycles, busy high 2 cycles, tick[2] first high 3 edges after LOAD edge, then every 3.
REQ-032 SHALL verify: cfg_div=0 on channel 1 -> tick[1] stays 0 for 100 cycles; reload cfg_div=1 -> tick[1] high every cycle after LOAD.
REQ-033 SHALL verify: run dropped for 7 cycles with cnt[0]=2, div=5 -> tick=0 during pause, tick[0] high on 3rd edge after run returns.
REQ-034 SHALL verify: LOAD on channel 0 coincident with its terminal count -> tick[0] not asserted that cycle; channels 1-3 tick normally.
REQ-035 SHALL verify: rst pulsed low during SYNC after cfg_div=9 -> all outputs at reset values immediately; channel period 5 afterwards.
